// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 16-bit SRAM controller.
package sram_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LO,
      HI,
      DONE
   } state_t;

   localparam int unsigned SRAM_DW           = 16;
   localparam int unsigned DEFAULT_BASE_ADDR = 1024;

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter: counts 0..WAIT_CYCLES-1 and wraps, tc flags the last cycle of a phase.
module sram_wait_counter #(
   parameter int unsigned WAIT_CYCLES = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tc
);

   localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

   logic [CW-1:0] count;

   assign tc = (count == LAST);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (tc) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/sram_controller.sv
// 32-bit word access over a 16-bit SRAM in two wait-stated phases (low half, then high half).
// Optional SRAM_ADDR_CHECK_EN adds a sticky addr_err output and skips the SRAM for bad addresses.
module sram_controller
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 5,
   parameter int unsigned SRAM_AW     = 18,
   parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               rd_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [SRAM_DW-1:0] sram_dq_out,
   input  logic [SRAM_DW-1:0] sram_dq_in,
   output logic               sram_dq_oe,
   output logic               sram_we_n
`ifdef SRAM_ADDR_CHECK_EN
   ,
   output logic               addr_err
`endif
);

   state_t             state;
   logic               op_write;
   logic [SRAM_AW-2:0] word;
   logic [31:0]        wdata;
   logic [15:0]        lo_half;
   logic               tc;
   logic               req;
   logic [SRAM_AW-2:0] req_word;

   assign req      = wr_en | rd_en;
   assign req_word = (SRAM_AW-1)'((address - 32'(BASE_ADDR)) >> 2);
   assign ready    = (state == DONE) | ((state == IDLE) & ~wr_en & ~rd_en);

`ifdef SRAM_ADDR_CHECK_EN
   logic addr_bad;
   assign addr_bad = (address < 32'(BASE_ADDR)) || (address[1:0] != 2'b00) ||
                     (((address - 32'(BASE_ADDR)) >> (SRAM_AW + 1)) != 32'd0);
`endif

   sram_wait_counter #(
      .WAIT_CYCLES(WAIT_CYCLES)
   ) u_wait (
      .clk  (clk),
      .rst  (rst),
      .clear((state != LO) && (state != HI)),
      .tc   (tc)
   );

   // Pin outputs are registered, so each phase's pin values are loaded on the edge entering it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         op_write    <= 1'b0;
         word        <= '0;
         wdata       <= '0;
         lo_half     <= '0;
         read_data   <= '0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
`ifdef SRAM_ADDR_CHECK_EN
         addr_err    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  op_write <= wr_en;
                  word     <= req_word;
                  wdata    <= write_data;
`ifdef SRAM_ADDR_CHECK_EN
                  if (addr_bad) begin
                     addr_err  <= 1'b1;
                     read_data <= '0;
                     state     <= DONE;
                  end else
`endif
                  begin
                     state       <= LO;
                     sram_addr   <= {req_word, 1'b0};
                     sram_dq_out <= write_data[15:0];
                     sram_dq_oe  <= wr_en;
                     sram_we_n   <= ~wr_en;
                  end
               end
            end
            LO: begin
               if (tc) begin
                  if (!op_write) lo_half <= sram_dq_in;
                  state       <= HI;
                  sram_addr   <= {word, 1'b1};
                  sram_dq_out <= wdata[31:16];
               end
            end
            HI: begin
               if (tc) begin
                  if (!op_write) read_data <= {sram_dq_in, lo_half};
                  sram_dq_oe <= 1'b0;
                  sram_we_n  <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed table, reset/abort sequences and random requests vs a word-level model.
module tb_sram_controller;

   localparam int unsigned W    = 5;
   localparam int unsigned BASE = 1024;
   localparam int unsigned NW   = 131072;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en, rd_en;
   logic [31:0] address, write_data, read_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out, sram_dq_in;
   logic        sram_dq_oe, sram_we_n;
`ifdef SRAM_ADDR_CHECK_EN
   logic        addr_err;
`endif

   sram_controller #(
      .WAIT_CYCLES(W),
      .SRAM_AW    (18),
      .BASE_ADDR  (BASE)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .ready      (ready),
      .sram_addr  (sram_addr),
      .sram_dq_out(sram_dq_out),
      .sram_dq_in (sram_dq_in),
      .sram_dq_oe (sram_dq_oe),
      .sram_we_n  (sram_we_n)
`ifdef SRAM_ADDR_CHECK_EN
      ,
      .addr_err   (addr_err)
`endif
   );

   always #5 clk = ~clk;

   // Pin-level SRAM device
   bit [15:0] sram_mem [0:(1<<18)-1];
   assign sram_dq_in = sram_mem[sram_addr];
   always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;

   // Word-level reference state
   logic [31:0] ref_mem [0:31];
   logic [31:0] last_read;
   bit          exp_err;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit ref_bad(input logic [31:0] a);
`ifdef SRAM_ADDR_CHECK_EN
      return (a < BASE) || (a % 4 != 0) || ((a - BASE) / 4 >= NW);
`else
      return 1'b0 && (a == 0);
`endif
   endfunction

   function automatic int unsigned ref_idx(input logic [31:0] a);
      return ((a - BASE) / 4) % NW;
   endfunction

   // Issue one request and watch the pins each cycle until ready rises.
   task automatic run_req(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output int low, output int bad);
      bit          err;
      bit          ph_hi;
      logic [17:0] exp_a;
      err   = ref_bad(a);
      wr_en = wr; rd_en = rd; address = a; write_data = d;
      low = 0; bad = 0;
      for (int c = 0; c < 200; c++) begin
         #1;
         if (ready) break;
         if (low == 0 || err) begin
            if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) bad++;
         end else begin
            ph_hi = (low > W);
            exp_a = 18'(2 * ref_idx(a) + (ph_hi ? 1 : 0));
            if (sram_addr !== exp_a) bad++;
            if (wr) begin
               if (sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1) bad++;
               if (sram_dq_out !== (ph_hi ? d[31:16] : d[15:0])) bad++;
            end else if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) bad++;
         end
         low++;
         @(negedge clk);
      end
      rdata = read_data;
      wr_en = 0; rd_en = 0;
      @(negedge clk);
   endtask

   task automatic req_check(input string name, input bit wr, input bit rd, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] exp_rd, input int exp_low);
      logic [31:0] rdata;
      int          low, bad;
      run_req(wr, rd, a, d, rdata, low, bad);
      check({name, "_rdata"}, rdata, exp_rd);
      check({name, "_ready_low"}, low, exp_low);
      check({name, "_pins"}, bad, 0);
   endtask

   typedef struct {
      bit          wr;
      bit          rd;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t tbl [5];

   initial begin
      logic [31:0] a, d, e;
      bit          wr, rd, err;
      int unsigned k;

      tbl[0] = '{1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h0000_0000};
      tbl[1] = '{1'b0, 1'b1, 32'd1028, 32'h0,        32'hABCD_1234};
      tbl[2] = '{1'b0, 1'b1, 32'd1024, 32'h0,        32'hDEAD_BEEF};
      tbl[3] = '{1'b1, 1'b1, 32'd1032, 32'h13579BDF, 32'hDEAD_BEEF};
      tbl[4] = '{1'b0, 1'b1, 32'd1032, 32'h0,        32'h1357_9BDF};

      sram_mem[2] = 16'h1234;
      sram_mem[3] = 16'hABCD;
      for (int i = 16; i < 32; i++) begin
         ref_mem[i] = $urandom;
         sram_mem[2*i]   = ref_mem[i][15:0];
         sram_mem[2*i+1] = ref_mem[i][31:16];
      end

      rst = 1; wr_en = 0; rd_en = 0; address = 0; write_data = 0;
      repeat (3) @(negedge clk);
      rst = 0;

      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         check("idle_ready", ready, 1'b1);
         check("idle_we_n", sram_we_n, 1'b1);
         check("idle_oe", sram_dq_oe, 1'b0);
      end
      check("reset_read_data", read_data, 32'h0);
      check("reset_sram_addr", sram_addr, 18'h0);
`ifdef SRAM_ADDR_CHECK_EN
      check("reset_addr_err", addr_err, 1'b0);
`endif
      @(negedge clk);

      for (int i = 0; i < 5; i++)
         req_check($sformatf("vec%0d", i), tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data,
                   tbl[i].exp_rd, 2 * W + 1);

      // Reset in the middle of the high-half write phase
      wr_en = 1; address = 32'd1040; write_data = 32'hCAFE_F00D;
      repeat (8) @(negedge clk);
      #1;
      check("abort_in_hi_addr", sram_addr, 18'd9);
      check("abort_in_hi_we_n", sram_we_n, 1'b0);
      rst = 1; wr_en = 0;
      @(negedge clk);
      rst = 0;
      #1;
      check("abort_ready", ready, 1'b1);
      check("abort_we_n", sram_we_n, 1'b1);
      check("abort_oe", sram_dq_oe, 1'b0);
      check("abort_read_data", read_data, 32'h0);
      @(negedge clk);
      last_read = 32'h0;
      exp_err   = 1'b0;

`ifdef SRAM_ADDR_CHECK_EN
      req_check("bad_addr", 1'b0, 1'b1, 32'd1000, 32'h0, 32'h0, 1);
      check("bad_addr_err", addr_err, 1'b1);
      req_check("after_bad", 1'b0, 1'b1, 32'd1088, 32'h0, ref_mem[16], 2 * W + 1);
      check("after_bad_err_sticky", addr_err, 1'b1);
      exp_err   = 1'b1;
      last_read = ref_mem[16];
`endif

      for (int n = 0; n < 40; n++) begin
         k  = $urandom_range(16, 31);
         a  = BASE + 4 * k;
         if ($urandom_range(0, 3) == 0) a += 4 * NW;
`ifdef SRAM_ADDR_CHECK_EN
         if ($urandom_range(0, 5) == 0) a = a - 2;
         if ($urandom_range(0, 7) == 0) a = 4 * $urandom_range(0, 255);
`endif
         d  = $urandom;
         wr = ($urandom_range(0, 2) != 1);
         rd = !wr || ($urandom_range(0, 1) == 1);
         err = ref_bad(a);
         if (err) begin
            e = 32'h0; last_read = 32'h0; exp_err = 1'b1;
         end else if (wr) begin
            ref_mem[ref_idx(a)] = d; e = last_read;
         end else begin
            e = ref_mem[ref_idx(a)]; last_read = e;
         end
         req_check($sformatf("rnd%0d", n), wr, rd, a, d, e, err ? 1 : 2 * W + 1);
`ifdef SRAM_ADDR_CHECK_EN
         check($sformatf("rnd%0d_err", n), addr_err, exp_err);
`endif
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
